acc_multicycle_ctrl: RTL and testbench
======================================

# acc_multicycle_ctrl

Parametrised multicycle controller for the accumulator processor: fetches instructions over a request/valid port, decodes opcode/source/destination/immediate fields, owns the A, B and ACC registers and the program counter, and sequences ALU, memory-read, memory-write, memory-clear and halt operations through an explicit state machine. It sits between the instruction memory, the data memory (variable-latency req/ack) and a combinational ALU sub-module. It replaces the single-cycle combinational control with registered, handshaked sequencing.

## Interface
- DATA_W, 32, data and instruction width; instruction fields: opcode [DATA_W-1:DATA_W-3], src [DATA_W-4:DATA_W-5], dst [DATA_W-6:DATA_W-7], imm [ADDR_W-1:0]
- ADDR_W, 25, data-memory address width; must be ≤ DATA_W-7
- PC_W, 16, program counter width
- CLR_WORDS, 16, words cleared by one MC instruction (≥1)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- inst_req  out  1  instruction fetch request
- pc  out  PC_W  fetch address
- inst_valid  in  1  instruction present on inst this cycle
- inst  in  DATA_W  instruction word
- mem_req  out  1  data memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  data address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  request completed; read data valid this cycle
- mem_rdata  in  DATA_W  read data
- reg_a, reg_b, acc  out  DATA_W  architectural registers (debug/observe)
- halted  out  1  processor stopped by HLT
- div0  out  1  sticky divide-by-zero flag

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 DIV, 011 MUL, 100 MC, 101 HLT, 110 MR, 111 MW.
- src code: 00 A, 01 B, 10 ACC, 11 constant zero. dst code: 00 A, 01 B, 1x ACC.
- ALU ops: ACC ← ACC op src, results truncated to DATA_W (mod 2^DATA_W); DIV unsigned, ACC ÷ src; src = 0 → ACC ← all ones, div0 ← 1 (sticky until reset).
- MR: dst ← mem[imm]. MW: mem[imm] ← src (zero when src = 11).
- MC: writes zero to imm, imm+1, … imm+CLR_WORDS-1, addresses wrapping modulo 2^ADDR_W.
- HLT: enter HALT; no further fetches; only RST_N exits.
- States: FETCH → EXEC (ALU, HLT) or MEM (MR, MW) or CLEAR (MC) → FETCH; HLT → HALT.
- FETCH: inst_req = 1, pc driven; on inst_valid latch inst, go to dispatch state. inst ignored when inst_valid = 0.
- EXEC: one cycle; ALU result written to ACC; pc ← pc+1 (wraps at 2^PC_W); → FETCH.
- MEM: mem_req held with stable mem_we/addr/wdata until mem_ack; on ack cycle MR writes dst, pc increments, → FETCH.
- CLEAR: internal counter 0..CLR_WORDS-1; each word one req/ack; after ack of last word pc increments, → FETCH.
- Reset (any state, any cycle, including mid-handshake): state FETCH, pc, reg_a, reg_b, acc, clear counter 0, inst_req/mem_req/mem_we/halted/div0 0, mem_addr/mem_wdata 0. A pending ack arriving after reset is ignored.

## Timing
- All outputs registered or decoded from registered state only; no combinational path inst/mem_ack → outputs.
- First inst_req high in first clock edge after RST_N deasserts (FETCH is reset state, inst_req combinational from state).
- ALU instruction with zero-wait fetch: 2 cycles (FETCH, EXEC).
- MR/MW: 1 fetch + (1 + ack wait) cycles; mem_ack same cycle as mem_req allowed.
- MC with zero-wait memory: 1 + CLR_WORDS cycles; mem_req stays high between words, mem_addr advances the cycle after each ack.
- halted rises the cycle after the HLT EXEC cycle and stays high.

## Structure
- Package acc_ctrl_pkg: opcode constants, src/dst codes, state enum (FETCH, EXEC, MEM, CLEAR, HALT), ALU op encoding.
- Sub-module acc_alu: combinational add/sub/mul/div with div-by-zero output; controller holds all state.

## Test plan
- Reset, program MR A←mem[5]=7; MR ACC←mem[6]=3; ADD src A → acc = 10, pc = 3.
- SUB src B with ACC=2, B=5 → acc = 0xFFFFFFFD (wrap); MUL 0x10000×0x10000 → acc = 0.
- DIV src zero with ACC=9 → acc = 0xFFFFFFFF, div0 = 1 and stays set after next ADD.
- MW src ACC=0x55 to imm 0x1FFFFFF with 3-cycle ack delay → mem_req held 4 cycles, address/data stable; MC imm=0x1FFFFFE, CLR_WORDS=4 → writes 0 to 0x1FFFFFE, 0x1FFFFFF, 0, 1.
- HLT → halted = 1, inst_req stays 0 for 100 cycles; RST_N pulse mid-MC (after 2 acks) → all outputs zero, fetch restarts at pc 0.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared encodings for the multicycle accumulator controller.
package acc_ctrl_pkg;

  // Instruction opcodes
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_MC  = 3'b100;
  localparam logic [2:0] OP_HLT = 3'b101;
  localparam logic [2:0] OP_MR  = 3'b110;
  localparam logic [2:0] OP_MW  = 3'b111;

  // Source operand codes
  localparam logic [1:0] SRC_A    = 2'b00;
  localparam logic [1:0] SRC_B    = 2'b01;
  localparam logic [1:0] SRC_ACC  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  // Destination codes (1x selects ACC)
  localparam logic [1:0] DST_A = 2'b00;
  localparam logic [1:0] DST_B = 2'b01;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    MEM,
    CLEAR,
    HALT
  } state_t;

  // ALU encoding equals the low two opcode bits of the ALU instructions
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_DIV = 2'b10,
    ALU_MUL = 2'b11
  } alu_op_t;

  // ALU instructions are exactly those with opcode MSB clear
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_MR) || (op == OP_MW) || (op == OP_MC);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU: ACC op src, truncated to DATA_W; unsigned divide.
module acc_alu
  import acc_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              div_zero
);

  // Result select; divide by zero saturates to all ones and flags it
  always_comb begin
    y        = '0;
    div_zero = 1'b0;
    case (alu_op_t'(op))
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;
      ALU_DIV: begin
        if (b == '0) begin
          y        = '1;
          div_zero = 1'b1;
        end else begin
          y = a / b;
        end
      end
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/acc_multicycle_ctrl.sv
// Multicycle controller: fetch, decode, and sequence ALU/memory/clear/halt.
module acc_multicycle_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 25,
  parameter int PC_W      = 16,
  parameter int CLR_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              inst_req,
  output logic [PC_W-1:0]   pc,
  input  logic              inst_valid,
  input  logic [DATA_W-1:0] inst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              div0
);

  localparam int CNT_W = (CLR_WORDS > 1) ? $clog2(CLR_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_WORDS - 1);

  state_t            state_reg;
  state_t            state_next;
  logic              run_reg;     // low until the first edge after reset release
  logic [2:0]        op_reg;
  logic [1:0]        src_reg;
  logic [1:0]        dst_reg;
  logic [CNT_W-1:0]  clr_cnt_reg;

  // Fields of the incoming instruction word
  logic [2:0]        inst_op;
  logic [1:0]        inst_src;
  logic [1:0]        inst_dst;
  logic [ADDR_W-1:0] inst_imm;

  assign inst_op  = inst[DATA_W-1 -: 3];
  assign inst_src = inst[DATA_W-4 -: 2];
  assign inst_dst = inst[DATA_W-6 -: 2];
  assign inst_imm = inst[ADDR_W-1:0];

  logic              fetch_take;
  logic              clr_last;
  logic [DATA_W-1:0] exec_src;
  logic [DATA_W-1:0] fetch_src;
  logic [DATA_W-1:0] alu_y;
  logic              alu_div_zero;

  assign fetch_take = (state_reg == FETCH) && run_reg && inst_valid;
  assign clr_last   = (clr_cnt_reg == CNT_LAST);

  // Operand muxes: latched src for EXEC, incoming src for MW write data
  always_comb begin
    exec_src  = '0;
    fetch_src = '0;
    case (src_reg)
      SRC_A:   exec_src = reg_a;
      SRC_B:   exec_src = reg_b;
      SRC_ACC: exec_src = acc;
      default: exec_src = '0;
    endcase
    case (inst_src)
      SRC_A:   fetch_src = reg_a;
      SRC_B:   fetch_src = reg_b;
      SRC_ACC: fetch_src = acc;
      default: fetch_src = '0;
    endcase
  end

  acc_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op       (op_reg[1:0]),
    .a        (acc),
    .b        (exec_src),
    .y        (alu_y),
    .div_zero (alu_div_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and state-decoded handshake outputs
  always_comb begin
    state_next = state_reg;
    inst_req   = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      FETCH: begin
        inst_req = run_reg;
        if (fetch_take) begin
          if (is_alu_op(inst_op) || (inst_op == OP_HLT)) begin
            state_next = EXEC;
          end else if (inst_op == OP_MC) begin
            state_next = CLEAR;
          end else begin
            state_next = MEM;
          end
        end
      end
      EXEC: begin
        state_next = (op_reg == OP_HLT) ? HALT : FETCH;
      end
      MEM: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = FETCH;
        end
      end
      CLEAR: begin
        mem_req = 1'b1;
        if (mem_ack && clr_last) begin
          state_next = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_next = FETCH;
    endcase
  end

  // Architectural registers, pc, decode latches and memory request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg     <= 1'b0;
      op_reg      <= '0;
      src_reg     <= '0;
      dst_reg     <= '0;
      clr_cnt_reg <= '0;
      pc          <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      acc         <= '0;
      div0        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        FETCH: begin
          if (fetch_take) begin
            op_reg      <= inst_op;
            src_reg     <= inst_src;
            dst_reg     <= inst_dst;
            clr_cnt_reg <= '0;
            if (is_mem_op(inst_op)) begin
              mem_addr  <= inst_imm;
              mem_we    <= (inst_op != OP_MR);
              mem_wdata <= (inst_op == OP_MW) ? fetch_src : '0;
            end
          end
        end
        EXEC: begin
          pc <= pc + 1'b1;
          if (is_alu_op(op_reg)) begin
            acc <= alu_y;
            if (alu_div_zero) begin
              div0 <= 1'b1;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            pc <= pc + 1'b1;
            if (op_reg == OP_MR) begin
              if (dst_reg == DST_A) begin
                reg_a <= mem_rdata;
              end else if (dst_reg == DST_B) begin
                reg_b <= mem_rdata;
              end else begin
                acc <= mem_rdata;
              end
            end
          end
        end
        CLEAR: begin
          if (mem_ack) begin
            if (clr_last) begin
              clr_cnt_reg <= '0;
              pc          <= pc + 1'b1;
            end else begin
              clr_cnt_reg <= clr_cnt_reg + 1'b1;
              mem_addr    <= mem_addr + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_multicycle_ctrl.sv
// Directed bench for acc_multicycle_ctrl with a write scoreboard.
module tb_acc_multicycle_ctrl;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 25;
  localparam int PC_W      = 16;
  localparam int CLR_WORDS = 4;

  logic              clk;
  logic              rst_n;
  logic              inst_req;
  logic [PC_W-1:0]   pc;
  logic              inst_valid;
  logic [DATA_W-1:0] inst;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] acc;
  logic              halted;
  logic              div0;

  acc_multicycle_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .PC_W      (PC_W),
    .CLR_WORDS (CLR_WORDS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_req   (inst_req),
    .pc         (pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .acc        (acc),
    .halted     (halted),
    .div0       (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [logic [24:0]];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];

  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          ack_count = 0;
  logic [31:0] first_addr;
  logic [31:0] first_wdata;
  logic        first_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [1:0] src,
                                      input logic [1:0] dst, input logic [24:0] imm);
    return {op, src, dst, imm};
  endfunction

  // Instruction port (zero wait) and data memory with programmable ack delay
  always @(negedge clk) begin
    inst_valid = inst_req;
    inst       = inst_req ? imem[pc[5:0]] : 32'h0;
    if (mem_req) begin
      if (wait_cnt == 0) begin
        first_addr  = 32'(mem_addr);
        first_wdata = mem_wdata;
        first_we    = mem_we;
      end else begin
        chk("addr_stable", 32'(mem_addr), first_addr);
        chk("wdata_stable", mem_wdata, first_wdata);
        chk("we_stable", 32'(mem_we), 32'(first_we));
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        ack_count++;
        wait_cnt = 0;
        if (mem_we) begin
          n_cmp++;
          assert (exp_addr.size() != 0) else begin
            n_bad++;
            $error("FAIL wr_unexpected: observed write %h<=%h expected none", mem_addr, mem_wdata);
          end
          if (exp_addr.size() != 0) begin
            chk("wr_addr", 32'(mem_addr), exp_addr.pop_front());
            chk("wr_data", mem_wdata, exp_data.pop_front());
          end
        end else begin
          mem_rdata = dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic wait_pc(input logic [15:0] target, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pc == target) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (hit) else begin
      n_bad++;
      $error("FAIL %s: observed pc %h expected %h before timeout", tag, pc, target);
    end
  endtask

  task automatic wait_halt(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (halted) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (hit) else begin
      n_bad++;
      $error("FAIL %s: observed halted %b expected 1 before timeout", tag, halted);
    end
  endtask

  // Counts mem_req-high negedges while pc stays at the given value
  task automatic count_req(input logic [15:0] at_pc, output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pc != at_pc) break;
      if (mem_req) n++;
    end
  endtask

  initial begin
    int n_req;
    int n_ireq;
    int base;
    bit hit;

    inst_valid = 1'b0;
    inst       = '0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < 64; i++) imem[i] = enc(3'b101, 2'b00, 2'b00, 25'h0);
    dmem[25'd5]  = 32'd7;
    dmem[25'd6]  = 32'd3;
    dmem[25'd7]  = 32'd5;
    dmem[25'd8]  = 32'd2;
    dmem[25'd9]  = 32'h0001_0000;
    dmem[25'd10] = 32'd9;
    dmem[25'd11] = 32'h55;

    // Program: loads, ALU wrap cases, divide by zero, MW, MC with wrap, HLT
    imem[0]  = enc(3'b110, 2'b00, 2'b00, 25'd5);        // MR A <- mem[5]
    imem[1]  = enc(3'b110, 2'b00, 2'b10, 25'd6);        // MR ACC <- mem[6]
    imem[2]  = enc(3'b000, 2'b00, 2'b00, 25'd0);        // ADD A
    imem[3]  = enc(3'b110, 2'b00, 2'b01, 25'd7);        // MR B <- 5
    imem[4]  = enc(3'b110, 2'b00, 2'b10, 25'd8);        // MR ACC <- 2
    imem[5]  = enc(3'b001, 2'b01, 2'b00, 25'd0);        // SUB B
    imem[6]  = enc(3'b110, 2'b00, 2'b00, 25'd9);        // MR A <- 0x10000
    imem[7]  = enc(3'b110, 2'b00, 2'b10, 25'd9);        // MR ACC <- 0x10000
    imem[8]  = enc(3'b011, 2'b00, 2'b00, 25'd0);        // MUL A
    imem[9]  = enc(3'b110, 2'b00, 2'b10, 25'd10);       // MR ACC <- 9
    imem[10] = enc(3'b010, 2'b11, 2'b00, 25'd0);        // DIV zero
    imem[11] = enc(3'b000, 2'b11, 2'b00, 25'd0);        // ADD zero
    imem[12] = enc(3'b110, 2'b00, 2'b10, 25'd11);       // MR ACC <- 0x55
    imem[13] = enc(3'b111, 2'b10, 2'b00, 25'h1FF_FFFF); // MW ACC
    imem[14] = enc(3'b100, 2'b00, 2'b00, 25'h1FF_FFFE); // MC
    imem[15] = enc(3'b101, 2'b00, 2'b00, 25'd0);        // HLT

    exp_addr.push_back(32'h01FF_FFFF); exp_data.push_back(32'h55);
    exp_addr.push_back(32'h01FF_FFFE); exp_data.push_back(32'h0);
    exp_addr.push_back(32'h01FF_FFFF); exp_data.push_back(32'h0);
    exp_addr.push_back(32'h0000_0000); exp_data.push_back(32'h0);
    exp_addr.push_back(32'h0000_0001); exp_data.push_back(32'h0);

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_inst_req", 32'(inst_req), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_acc", acc, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_inst_req", 32'(inst_req), 32'h1);

    wait_pc(16'd3, "to_pc3");
    chk("add_acc", acc, 32'd10);
    chk("add_pc", 32'(pc), 32'd3);
    wait_pc(16'd6, "to_pc6");
    chk("sub_acc", acc, 32'hFFFF_FFFD);
    wait_pc(16'd9, "to_pc9");
    chk("mul_acc", acc, 32'h0);
    wait_pc(16'd11, "to_pc11");
    chk("div_acc", acc, 32'hFFFF_FFFF);
    chk("div0_set", 32'(div0), 32'h1);
    wait_pc(16'd12, "to_pc12");
    chk("div0_sticky", 32'(div0), 32'h1);
    chk("add0_acc", acc, 32'hFFFF_FFFF);

    wait_pc(16'd13, "to_pc13");
    ack_delay = 3;
    count_req(16'd13, n_req);
    chk("mw_req_cycles", 32'(n_req), 32'd4);
    ack_delay = 0;
    chk("mw_pc", 32'(pc), 32'd14);
    count_req(16'd14, n_req);
    chk("mc_req_cycles", 32'(n_req), 32'(CLR_WORDS));

    wait_halt("halt");
    n_ireq = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inst_req || !halted) n_ireq++;
    end
    chk("halt_quiet", 32'(n_ireq), 32'h0);
    chk("phase1_sb_empty", 32'(exp_addr.size()), 32'h0);

    // Reset out of HALT, then reset again in the middle of an MC
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst2_halted", 32'(halted), 32'h0);
    chk("rst2_div0", 32'(div0), 32'h0);
    chk("rst2_acc", acc, 32'h0);
    imem[0] = enc(3'b110, 2'b00, 2'b00, 25'd5);     // MR A <- 7
    imem[1] = enc(3'b100, 2'b00, 2'b00, 25'h100);   // MC
    exp_addr.push_back(32'h100); exp_data.push_back(32'h0);
    exp_addr.push_back(32'h101); exp_data.push_back(32'h0);
    base = ack_count;
    @(negedge clk); rst_n = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack_count == base + 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    assert (hit) else begin
      n_bad++;
      $error("FAIL mc_two_acks: observed %0d acks expected %0d before timeout", ack_count - base, 3);
    end
    chk("mid_mc_reg_a", reg_a, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("rst3_mem_req", 32'(mem_req), 32'h0);
    chk("rst3_mem_we", 32'(mem_we), 32'h0);
    chk("rst3_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst3_mem_wdata", mem_wdata, 32'h0);
    chk("rst3_reg_a", reg_a, 32'h0);
    chk("rst3_pc", 32'(pc), 32'h0);
    chk("rst3_inst_req", 32'(inst_req), 32'h0);
    imem[0] = enc(3'b101, 2'b00, 2'b00, 25'd0);     // HLT
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_inst_req", 32'(inst_req), 32'h1);
    chk("restart_pc", 32'(pc), 32'h0);
    wait_halt("halt2");
    chk("phase2_sb_empty", 32'(exp_addr.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
